set_assoc_cache_sim: RTL and testbench

- Parametrised N-way set-associative cache simulator core; successor to the direct-mapped trace simulator top.
- Accepts one memory-trace address per valid/ready handshake and looks up all ways in parallel.
- On a miss, models refill with a fixed memory latency and replaces a victim under LRU or FIFO policy.
- Keeps saturating hit/miss counters; sits between the trace source (BRAM reader) and the statistics/display logic.

---
 rtl/set_assoc_cache_sim.sv | 276 +++++++++++++++++++++++++++
 tb/tb_set_assoc_cache_sim.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache_sim.sv
// -----------------------------------------------------------------------------
// set_assoc_cache_sim
//   N-way set-associative cache simulator core. It accepts one trace address
//   per valid/ready handshake, looks up every way of the indexed set in
//   parallel, models a miss refill with a fixed latency, picks a victim under
//   LRU or FIFO replacement, and keeps saturating hit/miss counters.
//
//   State | Meaning
//   ------+--------------------------------------------------------------
//   IDLE  | ready for a trace address; latch tag/index on accept
//   LOOKUP| parallel tag compare; pick hit way or victim way
//   FILL  | refill latency countdown; write tag/valid on terminal count
//   DONE  | pulse response, bump counter, update replacement state
//
// Ports
//   i_clk          clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_trace_valid  trace address valid
//   i_trace_addr   byte address being accessed
//   o_trace_ready  core can accept an address (IDLE only)
//   i_clear_stats  synchronous clear of both counters (wins over increment)
//   o_resp_valid   one-cycle pulse: access completed
//   o_resp_hit     hit/miss of completed access (valid with o_resp_valid)
//   o_resp_way     way hit or filled
//   o_cache_hit    saturating hit count
//   o_cache_miss   saturating miss count
// -----------------------------------------------------------------------------
module set_assoc_cache_sim #(
    parameter int WAYS            = 2,
    parameter int BLOCK_SIZE_BYTE = 64,
    parameter int CACHE_SIZE_BYTE = 16384,
    parameter int ADDR_W          = 32,
    parameter int POLICY          = 0,
    parameter int MISS_LATENCY    = 4,
    parameter int CNT_W           = 16,
    localparam int WAY_W          = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_trace_valid,
    input  logic [ADDR_W-1:0] i_trace_addr,
    output logic              o_trace_ready,
    input  logic              i_clear_stats,
    output logic              o_resp_valid,
    output logic              o_resp_hit,
    output logic [WAY_W-1:0]  o_resp_way,
    output logic [CNT_W-1:0]  o_cache_hit,
    output logic [CNT_W-1:0]  o_cache_miss
);

    localparam int OFF_W  = $clog2(BLOCK_SIZE_BYTE);
    localparam int SETS   = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAYS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int IDX_WS = (IDX_W > 0) ? IDX_W : 1;
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int LAT_W  = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;
    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_FILL   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Per set x way storage; ages form a permutation of 0..WAYS-1 per set.
    logic             r_valid    [SETS][WAYS];
    logic [TAG_W-1:0] r_tag      [SETS][WAYS];
    logic [WAY_W-1:0] r_age      [SETS][WAYS];
    logic [WAY_W-1:0] r_fifo_ptr [SETS];

    logic [TAG_W-1:0]  w_in_tag;
    logic [IDX_WS-1:0] w_in_idx;
    logic [TAG_W-1:0]  r_tag_q;
    logic [IDX_WS-1:0] r_idx_q;

    logic [WAYS-1:0]   w_match;
    logic              w_hit;
    logic [WAY_W-1:0]  w_hit_way;
    logic              w_any_invalid;
    logic [WAY_W-1:0]  w_inv_way;
    logic [WAY_W-1:0]  w_lru_way;
    logic [WAY_W-1:0]  w_victim;

    logic              r_hit;
    logic [WAY_W-1:0]  r_way;
    logic [LAT_W-1:0]  r_lat;

    logic              r_resp_valid;
    logic              r_resp_hit;
    logic [WAY_W-1:0]  r_resp_way;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [CNT_W-1:0]  r_miss_cnt;
    logic              w_ready;

    // Byte-offset bits never take part in the lookup.
    logic w_unused_off;
    assign w_unused_off = ^i_trace_addr[OFF_W-1:0];

    assign w_in_tag = i_trace_addr[ADDR_W-1 -: TAG_W];

    generate
        if (IDX_W > 0) begin : g_idx
            assign w_in_idx = i_trace_addr[OFF_W +: IDX_WS];
        end else begin : g_noidx
            assign w_in_idx = '0;
        end
    endgenerate

    // Parallel tag compare; lowest matching way wins (only one can match).
    always_comb begin
        w_match   = '0;
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_match[w] = r_valid[r_idx_q][w] && (r_tag[r_idx_q][w] == r_tag_q);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_match[w]) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest invalid way, else oldest way (LRU) or FIFO pointer.
    always_comb begin
        w_any_invalid = 1'b0;
        w_inv_way     = '0;
        w_lru_way     = '0;
        w_victim      = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[r_idx_q][w]) begin
                w_any_invalid = 1'b1;
                w_inv_way     = WAY_W'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (r_age[r_idx_q][w] == LAST_WAY) begin
                w_lru_way = WAY_W'(w);
            end
        end
        if (w_any_invalid) begin
            w_victim = w_inv_way;
        end else if (POLICY == 0) begin
            w_victim = w_lru_way;
        end else begin
            w_victim = r_fifo_ptr[r_idx_q];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (i_trace_valid) begin
                    w_state_nxt = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                w_state_nxt = w_hit ? S_DONE : S_FILL;
            end
            S_FILL: begin
                if (r_lat == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_tag[s][w]   <= '0;
                    r_age[s][w]   <= WAY_W'(w);
                end
                r_fifo_ptr[s] <= '0;
            end
            r_tag_q      <= '0;
            r_idx_q      <= '0;
            r_hit        <= 1'b0;
            r_way        <= '0;
            r_lat        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_way   <= '0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_trace_valid) begin
                        r_tag_q <= w_in_tag;
                        r_idx_q <= w_in_idx;
                    end
                end
                S_LOOKUP: begin
                    r_hit <= w_hit;
                    r_way <= w_hit ? w_hit_way : w_victim;
                    r_lat <= LAT_W'(MISS_LATENCY - 1);
                end
                S_FILL: begin
                    if (r_lat == '0) begin
                        r_valid[r_idx_q][r_way] <= 1'b1;
                        r_tag[r_idx_q][r_way]   <= r_tag_q;
                    end else begin
                        r_lat <= r_lat - 1'b1;
                    end
                end
                S_DONE: begin
                    r_resp_valid <= 1'b1;
                    r_resp_hit   <= r_hit;
                    r_resp_way   <= r_way;
                    if (r_hit) begin
                        if (r_hit_cnt != '1) begin
                            r_hit_cnt <= r_hit_cnt + 1'b1;
                        end
                    end else begin
                        if (r_miss_cnt != '1) begin
                            r_miss_cnt <= r_miss_cnt + 1'b1;
                        end
                    end
                    // Touched way becomes youngest; ways younger than it age by one.
                    for (int w = 0; w < WAYS; w++) begin
                        if (WAY_W'(w) == r_way) begin
                            r_age[r_idx_q][w] <= '0;
                        end else if (r_age[r_idx_q][w] < r_age[r_idx_q][r_way]) begin
                            r_age[r_idx_q][w] <= r_age[r_idx_q][w] + 1'b1;
                        end
                    end
                    // FIFO pointer only advances when a fill lands on it.
                    if (!r_hit && (r_way == r_fifo_ptr[r_idx_q])) begin
                        r_fifo_ptr[r_idx_q] <= (r_fifo_ptr[r_idx_q] == LAST_WAY) ?
                                               '0 : r_fifo_ptr[r_idx_q] + 1'b1;
                    end
                end
                default: begin
                end
            endcase
            if (i_clear_stats) begin
                r_hit_cnt  <= '0;
                r_miss_cnt <= '0;
            end
        end
    end

    assign o_trace_ready = w_ready;
    assign o_resp_valid  = r_resp_valid;
    assign o_resp_hit    = r_resp_hit;
    assign o_resp_way    = r_resp_way;
    assign o_cache_hit   = r_hit_cnt;
    assign o_cache_miss  = r_miss_cnt;

endmodule

// File: tb/tb_set_assoc_cache_sim.sv
// Bench for set_assoc_cache_sim: instance 0 runs LRU with 4-bit counters,
// instance 1 runs FIFO with 16-bit counters. A reference model keeps, per set,
// way contents plus a recency-ordered way list (front = most recent) and a
// FIFO pointer, and predicts hit/way/latency/counters for every access.
module tb_set_assoc_cache_sim;

    localparam int ML     = 4;
    localparam int M_SETS = 128;
    localparam int M_WAYS = 2;

    logic        clk;
    logic        rst;
    logic        tv  [2];
    logic [31:0] ta  [2];
    logic        clr [2];

    wire         rdy0, rdy1, rv0, rv1, rh0, rh1;
    wire  [0:0]  rw0, rw1;
    wire  [3:0]  ch0, cm0;
    wire  [15:0] ch1, cm1;

    int n_checks;
    int n_errors;

    set_assoc_cache_sim #(.POLICY(0), .MISS_LATENCY(ML), .CNT_W(4)) u_lru (
        .i_clk(clk), .i_reset(rst), .i_trace_valid(tv[0]), .i_trace_addr(ta[0]),
        .o_trace_ready(rdy0), .i_clear_stats(clr[0]), .o_resp_valid(rv0),
        .o_resp_hit(rh0), .o_resp_way(rw0), .o_cache_hit(ch0), .o_cache_miss(cm0)
    );

    set_assoc_cache_sim #(.POLICY(1), .MISS_LATENCY(ML), .CNT_W(16)) u_fifo (
        .i_clk(clk), .i_reset(rst), .i_trace_valid(tv[1]), .i_trace_addr(ta[1]),
        .o_trace_ready(rdy1), .i_clear_stats(clr[1]), .o_resp_valid(rv1),
        .o_resp_hit(rh1), .o_resp_way(rw1), .o_cache_hit(ch1), .o_cache_miss(cm1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    bit          mv   [2][M_SETS][M_WAYS];
    int unsigned mt   [2][M_SETS][M_WAYS];
    int          mptr [2][M_SETS];
    int          mq   [2][M_SETS][$];
    int unsigned mh   [2];
    int unsigned mm   [2];
    int unsigned mmax [2] = '{15, 65535};
    int          pol  [2] = '{0, 1};

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < M_SETS; s++) begin
                for (int w = 0; w < M_WAYS; w++) begin
                    mv[k][s][w] = 1'b0;
                    mt[k][s][w] = 0;
                end
                mptr[k][s] = 0;
                mq[k][s].delete();
                for (int w = 0; w < M_WAYS; w++) mq[k][s].push_back(w);
            end
            mh[k] = 0;
            mm[k] = 0;
        end
    endfunction

    function automatic void model_access(input int k, input logic [31:0] a,
                                         output bit hit, output int way);
        int s;
        int unsigned t;
        bit found;
        int pos;
        s     = int'((a >> 6) % M_SETS);
        t     = a >> 13;
        hit   = 1'b0;
        way   = 0;
        found = 1'b0;
        for (int w = 0; w < M_WAYS; w++) begin
            if (!hit && mv[k][s][w] && mt[k][s][w] == t) begin
                hit = 1'b1;
                way = w;
            end
        end
        if (!hit) begin
            for (int w = 0; w < M_WAYS; w++) begin
                if (!found && !mv[k][s][w]) begin
                    found = 1'b1;
                    way   = w;
                end
            end
            if (!found) way = (pol[k] == 0) ? mq[k][s][M_WAYS-1] : mptr[k][s];
            mv[k][s][way] = 1'b1;
            mt[k][s][way] = t;
            if (way == mptr[k][s]) mptr[k][s] = (mptr[k][s] + 1) % M_WAYS;
        end
        pos = -1;
        for (int i = 0; i < mq[k][s].size(); i++) if (mq[k][s][i] == way) pos = i;
        if (pos >= 0) mq[k][s].delete(pos);
        mq[k][s].push_front(way);
        if (hit) begin
            if (mh[k] < mmax[k]) mh[k]++;
        end else begin
            if (mm[k] < mmax[k]) mm[k]++;
        end
    endfunction

    // ---------------- helpers ----------------
    // which: 0 ready, 1 resp_valid, 2 resp_hit, 3 resp_way, 4 hits, 5 misses
    function automatic logic [31:0] obs(input int k, input int which);
        logic [31:0] r;
        r = '0;
        case (which)
            0: r = {31'b0, (k == 0) ? rdy0 : rdy1};
            1: r = {31'b0, (k == 0) ? rv0 : rv1};
            2: r = {31'b0, (k == 0) ? rh0 : rh1};
            3: r = {31'b0, (k == 0) ? rw0 : rw1};
            4: r = (k == 0) ? {28'b0, ch0} : {16'b0, ch1};
            5: r = (k == 0) ? {28'b0, cm0} : {16'b0, cm1};
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_counters(input int k, input string tag);
        check($sformatf("i%0d_%s_hits", k, tag), obs(k, 4), mh[k]);
        check($sformatf("i%0d_%s_misses", k, tag), obs(k, 5), mm[k]);
    endtask

    // Called #1 after a rising edge with the instance idle.
    task automatic do_access(input int k, input logic [31:0] a, input bit clr_done);
        bit exp_hit;
        int exp_way;
        int exp_lat;
        int n;
        bit got;
        bit ready_ok;
        model_access(k, a, exp_hit, exp_way);
        if (clr_done) begin
            mh[k] = 0;
            mm[k] = 0;
        end
        exp_lat = exp_hit ? 2 : 2 + ML;
        tv[k] = 1'b1;
        ta[k] = a;
        @(posedge clk); #1;
        tv[k]    = 1'b0;
        n        = 0;
        got      = 1'b0;
        ready_ok = (obs(k, 0) == 0);
        while (!got && n < 20) begin
            if (clr_done && n == exp_lat - 1) clr[k] = 1'b1;
            @(posedge clk); #1;
            n++;
            clr[k] = 1'b0;
            if (obs(k, 1) == 1) got = 1'b1;
            else if (obs(k, 0) != 0) ready_ok = 1'b0;
        end
        check($sformatf("i%0d_resp_seen_%0h", k, a), {31'b0, got}, 1);
        check($sformatf("i%0d_latency_%0h", k, a), n, exp_lat);
        check($sformatf("i%0d_hit_%0h", k, a), obs(k, 2), {31'b0, exp_hit});
        check($sformatf("i%0d_way_%0h", k, a), obs(k, 3), exp_way);
        check($sformatf("i%0d_ready_low_%0h", k, a), {31'b0, ready_ok}, 1);
        check($sformatf("i%0d_ready_back_%0h", k, a), obs(k, 0), 1);
        check_counters(k, "access");
        @(posedge clk); #1;
        check($sformatf("i%0d_pulse_end_%0h", k, a), obs(k, 1), 0);
    endtask

    // Hold trace_valid high across several hits; expects one response per 3 cycles.
    task automatic hold_valid(input int k, input logic [31:0] a, input int nacc);
        bit exp_hit;
        int exp_way;
        int n;
        int pulses;
        tv[k]  = 1'b1;
        ta[k]  = a;
        n      = 0;
        pulses = 0;
        while (pulses < nacc && n < 3 * nacc + 6) begin
            @(posedge clk); #1;
            n++;
            if (obs(k, 1) == 1) begin
                pulses++;
                model_access(k, a, exp_hit, exp_way);
                check($sformatf("i%0d_hold_spacing%0d", k, pulses), n, 3 * pulses);
                check($sformatf("i%0d_hold_hit%0d", k, pulses), obs(k, 2), {31'b0, exp_hit});
                check($sformatf("i%0d_hold_way%0d", k, pulses), obs(k, 3), exp_way);
                if (pulses == nacc) tv[k] = 1'b0;
            end
        end
        tv[k] = 1'b0;
        check($sformatf("i%0d_hold_pulses", k), pulses, nacc);
        check_counters(k, "hold");
        @(posedge clk); #1;
        check($sformatf("i%0d_hold_no_extra", k), obs(k, 1), 0);
        @(posedge clk); #1;
    endtask

    task automatic clear_idle(input int k);
        clr[k] = 1'b1;
        @(posedge clk); #1;
        clr[k] = 1'b0;
        mh[k]  = 0;
        mm[k]  = 0;
        check_counters(k, "clear_idle");
        check($sformatf("i%0d_clear_ready", k), obs(k, 0), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("i%0d_%s_ready", k, tag), obs(k, 0), 1);
            check($sformatf("i%0d_%s_rvalid", k, tag), obs(k, 1), 0);
            check($sformatf("i%0d_%s_rhit", k, tag), obs(k, 2), 0);
            check($sformatf("i%0d_%s_rway", k, tag), obs(k, 3), 0);
            check($sformatf("i%0d_%s_hits", k, tag), obs(k, 4), 0);
            check($sformatf("i%0d_%s_misses", k, tag), obs(k, 5), 0);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] a;
        int          k;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tv[i]  = 1'b0;
            ta[i]  = '0;
            clr[i] = 1'b0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic sequence and LRU replacement.
        do_access(0, 32'h0000, 1'b0);
        do_access(0, 32'h0004, 1'b0);
        do_access(0, 32'h2000, 1'b0);
        do_access(0, 32'h0000, 1'b0);
        do_access(0, 32'h4000, 1'b0);
        do_access(0, 32'h2000, 1'b0);
        do_access(0, 32'h4000, 1'b0);

        // FIFO replacement.
        do_access(1, 32'h0000, 1'b0);
        do_access(1, 32'h2000, 1'b0);
        do_access(1, 32'h0000, 1'b0);
        do_access(1, 32'h4000, 1'b0);
        do_access(1, 32'h0000, 1'b0);

        // Back-to-back throughput with trace_valid held.
        hold_valid(0, 32'h4000, 3);

        // Saturation of the 4-bit hit counter, then clear colliding with DONE.
        clear_idle(0);
        for (int i = 0; i < 17; i++) do_access(0, 32'h4000, 1'b0);
        do_access(0, 32'h4000, 1'b1);

        // Randomised traffic over a few sets and tags.
        for (int i = 0; i < 80; i++) begin
            k = int'($urandom_range(0, 1));
            a = ($urandom_range(0, 2) << 13) | ($urandom_range(0, 2) << 6) |
                $urandom_range(0, 63);
            do_access(k, a, ($urandom_range(0, 9) == 0));
        end

        // Reset in the middle of a refill.
        tv[0] = 1'b1;
        ta[0] = 32'h6000;
        @(posedge clk); #1;
        tv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midfill");
        #2;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        do_access(0, 32'h6000, 1'b0);
        do_access(0, 32'h6000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
